// File: rtl/arb_req_sequencer.sv
// Request-side sequencer feeding a 3-way priority grant FSM: per-channel burst
// queues, request/beat/gap sequencing, and sticky protocol error flags.
module arb_req_sequencer #(
   parameter int unsigned LEN_W  = 4,
   parameter int unsigned QDEPTH = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [2:0]           cmd_valid,
   input  logic [3*LEN_W-1:0]   cmd_len,
   output logic [2:0]           cmd_ready,
   output logic [2:0]           r,
   input  logic [2:0]           g,
   output logic [2:0]           beat,
   output logic [2:0]           done,
   output logic [2:0]           err_stray,
   output logic                 err_multi
);

   localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

   typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

   state_t           st   [3];
   logic [LEN_W-1:0] cnt  [3];
   logic [LEN_W-1:0] q_mem[3][QDEPTH];
   logic [PTR_W-1:0] wptr [3];
   logic [PTR_W-1:0] rptr [3];
   logic [CNT_W-1:0] qcnt [3];
   logic [2:0]       g_q;

   logic [2:0]       push;
   logic [2:0]       pop;
   logic [LEN_W-1:0] head [3];

   // Queue handshakes and output decode, all from registered state
   always_comb begin
      push      = '0;
      pop       = '0;
      cmd_ready = '0;
      r         = '0;
      done      = '0;
      beat      = '0;
      for (int i = 0; i < 3; i++) begin
         head[i]      = q_mem[i][rptr[i]];
         cmd_ready[i] = (qcnt[i] < CNT_W'(QDEPTH));
         push[i]      = cmd_valid[i] & cmd_ready[i];
         r[i]         = (st[i] == REQ) || (st[i] == XFER);
         done[i]      = (st[i] == GAP);
         beat[i]      = g[i] & r[i];
         // Pop on the edge that moves REQ/XFER into GAP
         pop[i]       = g[i] && (((st[i] == REQ) && (head[i] == '0)) ||
                                 ((st[i] == XFER) && (cnt[i] == '0)));
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < 3; i++) begin
            st[i]   <= IDLE;
            cnt[i]  <= '0;
            wptr[i] <= '0;
            rptr[i] <= '0;
            qcnt[i] <= '0;
         end
         g_q       <= '0;
         err_stray <= '0;
         err_multi <= 1'b0;
      end else begin
         g_q <= g;
         if ($countones(g) > 1) err_multi <= 1'b1;
         for (int i = 0; i < 3; i++) begin
            if (push[i]) begin
               q_mem[i][wptr[i]] <= cmd_len[i*LEN_W +: LEN_W];
               wptr[i] <= (wptr[i] == PTR_W'(QDEPTH - 1)) ? '0 : wptr[i] + 1'b1;
            end
            if (pop[i])
               rptr[i] <= (rptr[i] == PTR_W'(QDEPTH - 1)) ? '0 : rptr[i] + 1'b1;
            if (push[i] && !pop[i])
               qcnt[i] <= qcnt[i] + 1'b1;
            else if (!push[i] && pop[i])
               qcnt[i] <= qcnt[i] - 1'b1;

            // A single overhang grant cycle in GAP is expected; anything else is stray
            if (g[i] && ((st[i] == IDLE) || ((st[i] == GAP) && !g_q[i])))
               err_stray[i] <= 1'b1;

            case (st[i])
               IDLE: if (qcnt[i] != '0) st[i] <= REQ;
               REQ: begin
                  if (g[i]) begin
                     if (head[i] == '0) begin
                        st[i] <= GAP;
                     end else begin
                        st[i]  <= XFER;
                        cnt[i] <= head[i] - 1'b1;
                     end
                  end
               end
               XFER: begin
                  if (g[i]) begin
                     if (cnt[i] == '0) st[i] <= GAP;
                     else              cnt[i] <= cnt[i] - 1'b1;
                  end
               end
               GAP:     st[i] <= IDLE;
               default: st[i] <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_arb_req_sequencer.sv
// Directed testbench for arb_req_sequencer with a behavioural priority arbiter.
module tb_arb_req_sequencer;

   localparam int unsigned LEN_W = 4;

   logic               clk = 1'b0;
   logic               resetn;
   logic [2:0]         cmd_valid;
   logic [3*LEN_W-1:0] cmd_len;
   logic [2:0]         cmd_ready;
   logic [2:0]         r;
   logic [2:0]         g;
   logic [2:0]         beat;
   logic [2:0]         done;
   logic [2:0]         err_stray;
   logic               err_multi;

   logic               arb_en;
   logic [2:0]         arb_g;
   logic [2:0]         g_force;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int beats_tot[3];
   int dones_tot[3];
   int last_done[3];

   arb_req_sequencer #(.LEN_W(LEN_W), .QDEPTH(2)) dut (
      .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_len(cmd_len),
      .cmd_ready(cmd_ready), .r(r), .g(g), .beat(beat), .done(done),
      .err_stray(err_stray), .err_multi(err_multi)
   );

   always #5 clk = ~clk;

   assign g = arb_en ? arb_g : g_force;

   // Priority arbiter 0>1>2: holds while requested, idles one cycle after release
   always @(posedge clk) begin
      if (!resetn || !arb_en)        arb_g <= 3'b000;
      else if ((arb_g & r) != 3'b000) arb_g <= arb_g;
      else if (arb_g != 3'b000)       arb_g <= 3'b000;
      else if (r[0])                  arb_g <= 3'b001;
      else if (r[1])                  arb_g <= 3'b010;
      else if (r[2])                  arb_g <= 3'b100;
      else                            arb_g <= 3'b000;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      for (int i = 0; i < 3; i++) begin
         beats_tot[i] = 0;
         dones_tot[i] = 0;
         last_done[i] = 0;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (beat[i]) beats_tot[i] = beats_tot[i] + 1;
         if (done[i]) begin
            dones_tot[i] = dones_tot[i] + 1;
            last_done[i] = cyc;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      tick(2);
      total++; if (r !== 3'b000) begin bad++; $display("FAIL rst_r r=%b exp=000", r); end
      total++; if (beat !== 3'b000 || done !== 3'b000) begin bad++; $display("FAIL rst_beat_done beat=%b done=%b exp=000/000", beat, done); end
      total++; if (cmd_ready !== 3'b111) begin bad++; $display("FAIL rst_ready cmd_ready=%b exp=111", cmd_ready); end
      total++; if (err_stray !== 3'b000 || err_multi !== 1'b0) begin bad++; $display("FAIL rst_err stray=%b multi=%b exp=000/0", err_stray, err_multi); end
      resetn = 1'b1;
      tick(1);
   endtask

   task automatic test_single_burst();
      arb_en = 1'b1;
      cmd_valid = 3'b001; cmd_len = 12'h002;
      tick(1);
      cmd_valid = 3'b000;
      total++; if (r !== 3'b000) begin bad++; $display("FAIL sb_e0_r r=%b exp=000", r); end
      tick(1);
      total++; if (r !== 3'b001 || beat !== 3'b000) begin bad++; $display("FAIL sb_e1 r=%b beat=%b exp=001/000", r, beat); end
      for (int k = 2; k <= 4; k++) begin
         tick(1);
         total++; if (beat !== 3'b001 || r !== 3'b001) begin bad++; $display("FAIL sb_beat%0d beat=%b r=%b exp=001/001", k, beat, r); end
      end
      tick(1);
      total++; if (done !== 3'b001 || r !== 3'b000 || beat !== 3'b000) begin bad++; $display("FAIL sb_gap done=%b r=%b beat=%b exp=001/000/000", done, r, beat); end
      tick(1);
      total++; if (done !== 3'b000 || r !== 3'b000) begin bad++; $display("FAIL sb_idle done=%b r=%b exp=000/000", done, r); end
      total++; if (err_stray !== 3'b000) begin bad++; $display("FAIL sb_overhang err_stray=%b exp=000", err_stray); end
      total++; if (cmd_ready !== 3'b111) begin bad++; $display("FAIL sb_ready cmd_ready=%b exp=111", cmd_ready); end
   endtask

   task automatic test_contention();
      int b0, b1, b2, start;
      b0 = beats_tot[0]; b1 = beats_tot[1]; b2 = beats_tot[2]; start = cyc;
      cmd_valid = 3'b101; cmd_len = 12'h001;
      tick(1);
      cmd_valid = 3'b000;
      tick(1);
      total++; if (r !== 3'b101) begin bad++; $display("FAIL ct_req r=%b exp=101", r); end
      tick(1);
      total++; if (beat !== 3'b001) begin bad++; $display("FAIL ct_first beat=%b exp=001", beat); end
      tick(10);
      total++; if (beats_tot[0] - b0 != 2 || beats_tot[2] - b2 != 1 || beats_tot[1] - b1 != 0)
         begin bad++; $display("FAIL ct_beats ch0=%0d ch1=%0d ch2=%0d exp=2/0/1", beats_tot[0]-b0, beats_tot[1]-b1, beats_tot[2]-b2); end
      total++; if (!(last_done[0] > start && last_done[2] > last_done[0]))
         begin bad++; $display("FAIL ct_order done0_cyc=%0d done2_cyc=%0d exp done0<done2", last_done[0], last_done[2]); end
      total++; if (err_stray !== 3'b000 || err_multi !== 1'b0) begin bad++; $display("FAIL ct_err stray=%b multi=%b exp=000/0", err_stray, err_multi); end
   endtask

   task automatic test_back_to_back();
      cmd_valid = 3'b011; cmd_len = 12'h000;
      tick(1);
      cmd_valid = 3'b001;
      tick(1);
      cmd_valid = 3'b000;
      total++; if (r !== 3'b011) begin bad++; $display("FAIL bb_req r=%b exp=011", r); end
      tick(1);
      total++; if (beat !== 3'b001) begin bad++; $display("FAIL bb_beat0 beat=%b exp=001", beat); end
      tick(1);
      total++; if (done !== 3'b001 || r !== 3'b010) begin bad++; $display("FAIL bb_gap0 done=%b r=%b exp=001/010", done, r); end
      tick(1);
      total++; if (r !== 3'b010 || done !== 3'b000) begin bad++; $display("FAIL bb_low2 r=%b done=%b exp=010/000", r, done); end
      tick(1);
      total++; if (beat !== 3'b010 || r !== 3'b011) begin bad++; $display("FAIL bb_ch1 beat=%b r=%b exp=010/011", beat, r); end
      tick(1);
      total++; if (done !== 3'b010 || r !== 3'b001) begin bad++; $display("FAIL bb_done1 done=%b r=%b exp=010/001", done, r); end
      tick(1);
      total++; if (beat !== 3'b000 || r !== 3'b001) begin bad++; $display("FAIL bb_wait beat=%b r=%b exp=000/001", beat, r); end
      tick(1);
      total++; if (beat !== 3'b001) begin bad++; $display("FAIL bb_beat0b beat=%b exp=001", beat); end
      tick(1);
      total++; if (done !== 3'b001) begin bad++; $display("FAIL bb_done0b done=%b exp=001", done); end
      tick(2);
   endtask

   task automatic test_queue_full();
      int b1, d1;
      arb_en = 1'b0; g_force = 3'b000;
      cmd_valid = 3'b010; cmd_len = 12'h000;
      tick(1);
      total++; if (cmd_ready[1] !== 1'b1) begin bad++; $display("FAIL qf_push1 ready1=%b exp=1", cmd_ready[1]); end
      tick(1);
      total++; if (cmd_ready[1] !== 1'b0) begin bad++; $display("FAIL qf_push2 ready1=%b exp=0", cmd_ready[1]); end
      tick(1);
      total++; if (cmd_ready[1] !== 1'b0 || r !== 3'b010) begin bad++; $display("FAIL qf_stall ready1=%b r=%b exp=0/010", cmd_ready[1], r); end
      cmd_valid = 3'b000;
      b1 = beats_tot[1]; d1 = dones_tot[1];
      arb_en = 1'b1;
      tick(1);
      total++; if (beat !== 3'b010 || cmd_ready[1] !== 1'b0) begin bad++; $display("FAIL qf_beat beat=%b ready1=%b exp=010/0", beat, cmd_ready[1]); end
      tick(1);
      total++; if (done !== 3'b010 || cmd_ready[1] !== 1'b1) begin bad++; $display("FAIL qf_pop done=%b ready1=%b exp=010/1", done, cmd_ready[1]); end
      tick(13);
      total++; if (beats_tot[1] - b1 != 2 || dones_tot[1] - d1 != 2)
         begin bad++; $display("FAIL qf_bursts beats=%0d dones=%0d exp=2/2", beats_tot[1]-b1, dones_tot[1]-d1); end
      total++; if (cmd_ready !== 3'b111 || r !== 3'b000) begin bad++; $display("FAIL qf_drain ready=%b r=%b exp=111/000", cmd_ready, r); end
   endtask

   task automatic test_reset_mid_burst();
      int d0;
      arb_en = 1'b0; g_force = 3'b000;
      cmd_valid = 3'b001; cmd_len = 12'h006;
      tick(1);
      tick(1);
      cmd_valid = 3'b000;
      g_force = 3'b001;
      tick(1);
      total++; if (beat !== 3'b001 || r !== 3'b001) begin bad++; $display("FAIL rm_xfer beat=%b r=%b exp=001/001", beat, r); end
      d0 = dones_tot[0];
      resetn = 1'b0; g_force = 3'b000;
      tick(1);
      total++; if (r !== 3'b000 || beat !== 3'b000 || done !== 3'b000) begin bad++; $display("FAIL rm_rst r=%b beat=%b done=%b exp=000/000/000", r, beat, done); end
      total++; if (cmd_ready !== 3'b111) begin bad++; $display("FAIL rm_ready cmd_ready=%b exp=111", cmd_ready); end
      resetn = 1'b1;
      tick(3);
      total++; if (r !== 3'b000 || dones_tot[0] != d0) begin bad++; $display("FAIL rm_empty r=%b dones=%0d exp=000/%0d", r, dones_tot[0], d0); end
      total++; if (err_stray !== 3'b000) begin bad++; $display("FAIL rm_err err_stray=%b exp=000", err_stray); end
   endtask

   task automatic test_errors();
      arb_en = 1'b0;
      g_force = 3'b010;
      tick(1);
      total++; if (err_stray !== 3'b010 || err_multi !== 1'b0) begin bad++; $display("FAIL er_stray stray=%b multi=%b exp=010/0", err_stray, err_multi); end
      g_force = 3'b000;
      tick(2);
      total++; if (err_stray !== 3'b010) begin bad++; $display("FAIL er_sticky stray=%b exp=010", err_stray); end
      g_force = 3'b011;
      tick(1);
      total++; if (err_multi !== 1'b1 || err_stray !== 3'b011) begin bad++; $display("FAIL er_multi multi=%b stray=%b exp=1/011", err_multi, err_stray); end
      g_force = 3'b000;
      tick(2);
      total++; if (err_multi !== 1'b1 || err_stray !== 3'b011) begin bad++; $display("FAIL er_hold multi=%b stray=%b exp=1/011", err_multi, err_stray); end
      total++; if (r !== 3'b000 || cmd_ready !== 3'b111) begin bad++; $display("FAIL er_noeffect r=%b ready=%b exp=000/111", r, cmd_ready); end
      resetn = 1'b0;
      tick(1);
      resetn = 1'b1;
      tick(1);
      total++; if (err_multi !== 1'b0 || err_stray !== 3'b000) begin bad++; $display("FAIL er_clear multi=%b stray=%b exp=0/000", err_multi, err_stray); end
   endtask

   initial begin
      resetn = 1'b0; cmd_valid = 3'b000; cmd_len = '0;
      arb_en = 1'b0; g_force = 3'b000;
      tick(1);
      test_reset();
      test_single_burst();
      test_contention();
      test_back_to_back();
      test_queue_full();
      test_reset_mid_burst();
      test_errors();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
